// File: rtl/aes_pkg.sv
// Shared AES types, FSM encoding and GF(2^8) helpers for the CTR engine and the AES core.
// The S-box is computed as a field inverse plus affine map rather than stored as a table.
package aes_pkg;

    localparam int unsigned AES_BLK_W = 128;
    localparam int unsigned AES_KEY_W = 128;

    typedef logic [AES_BLK_W-1:0] aes_block_t;

    typedef enum logic [1:0] {IDLE, GEN, WAIT_IN, WAIT_OUT} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Inverse is a^254 (0 maps to 0), followed by the AES affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] a2, a3, a12, a240, inv;
        a2   = gf_mul(a, a);
        a3   = gf_mul(a2, a);
        a12  = gf_mul(gf_mul(a3, a3), gf_mul(a3, a3));
        a240 = gf_mul(a12, a3);
        for (int i = 0; i < 4; i++) a240 = gf_mul(a240, a240);
        inv  = gf_mul(gf_mul(a240, a12), a2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_ctr_engine_if.sv
// Configuration, input-stream and output-stream signals of the AES-CTR engine.
interface aes_ctr_engine_if;
    import aes_pkg::*;

    logic                 cfg_load;
    logic [AES_KEY_W-1:0] cfg_key;
    aes_block_t           cfg_iv;
    logic                 in_valid;
    logic                 in_ready;
    aes_block_t           in_data;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    aes_block_t           out_data;
    logic                 out_last;
    logic                 busy;

    modport master (
        output cfg_load, cfg_key, cfg_iv, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy
    );

    modport slave (
        input  cfg_load, cfg_key, cfg_iv, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, busy
    );

endinterface

// File: rtl/aes_core.sv
// Combinational AES-128 encryption: on-the-fly key schedule and ten unrolled rounds.
// Byte i of a block sits at bits [127-8*i -: 8]; column c holds bytes 4c..4c+3.
module aes_core
    import aes_pkg::*;
(
    input  logic [AES_KEY_W-1:0] key,
    input  aes_block_t           block_in,
    output aes_block_t           block_out
);

    always_comb begin : p_rounds
        logic [7:0]  st  [16];
        logic [7:0]  tmp [16];
        logic [31:0] w   [4];
        logic [31:0] t;
        logic [7:0]  rcon;

        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 0; i < 16; i++) st[i] = block_in[127-8*i -: 8] ^ key[127-8*i -: 8];
        rcon = 8'h01;

        for (int r = 1; r <= 10; r++) begin
            t = {sbox(w[3][23:16]), sbox(w[3][15:8]), sbox(w[3][7:0]), sbox(w[3][31:24])}
              ^ {rcon, 24'h000000};
            w[0] = w[0] ^ t;
            w[1] = w[1] ^ w[0];
            w[2] = w[2] ^ w[1];
            w[3] = w[3] ^ w[2];
            rcon = xtime(rcon);

            // SubBytes fused with ShiftRows: row rr rotates left by rr columns.
            for (int c = 0; c < 4; c++) begin
                for (int rr = 0; rr < 4; rr++) tmp[4*c+rr] = sbox(st[4*((c+rr)%4)+rr]);
            end

            for (int c = 0; c < 4; c++) begin
                if (r != 10) begin
                    st[4*c]   = xtime(tmp[4*c]) ^ xtime(tmp[4*c+1]) ^ tmp[4*c+1]
                              ^ tmp[4*c+2] ^ tmp[4*c+3];
                    st[4*c+1] = tmp[4*c] ^ xtime(tmp[4*c+1]) ^ xtime(tmp[4*c+2])
                              ^ tmp[4*c+2] ^ tmp[4*c+3];
                    st[4*c+2] = tmp[4*c] ^ tmp[4*c+1] ^ xtime(tmp[4*c+2])
                              ^ xtime(tmp[4*c+3]) ^ tmp[4*c+3];
                    st[4*c+3] = xtime(tmp[4*c]) ^ tmp[4*c] ^ tmp[4*c+1] ^ tmp[4*c+2]
                              ^ xtime(tmp[4*c+3]);
                end else begin
                    for (int rr = 0; rr < 4; rr++) st[4*c+rr] = tmp[4*c+rr];
                end
                for (int rr = 0; rr < 4; rr++) st[4*c+rr] = st[4*c+rr] ^ w[c][31-8*rr -: 8];
            end
        end

        for (int i = 0; i < 16; i++) block_out[127-8*i -: 8] = st[i];
    end

endmodule

// File: rtl/aes_ctr_engine.sv
// AES-128 counter-mode engine: one keystream block per message block, XORed onto a handshaked
// 128-bit stream. Encryption and decryption are the same operation.
module aes_ctr_engine
    import aes_pkg::*;
#(
    parameter int unsigned CTR_WIDTH = 32
) (
    input logic             clk,
    input logic             rst_n,
    aes_ctr_engine_if.slave bus
);

    // Only the low CTR_WIDTH bits count; the rest of the block is a fixed nonce.
    localparam aes_block_t CtrMask = {AES_BLK_W{1'b1}} >> (AES_BLK_W - CTR_WIDTH);

    state_t               state_q, state_d;
    logic [AES_KEY_W-1:0] key_q, key_d;
    aes_block_t           ctr_q, ctr_d;
    aes_block_t           ks_q, ks_d;
    aes_block_t           odata_q, odata_d;
    logic                 olast_q, olast_d;
    logic                 ovalid_q, ovalid_d;
    aes_block_t           ks_next;

    aes_core u_aes_core (
        .key       (key_q),
        .block_in  (ctr_q),
        .block_out (ks_next)
    );

    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        ctr_d    = ctr_q;
        ks_d     = ks_q;
        odata_d  = odata_q;
        olast_d  = olast_q;
        ovalid_d = ovalid_q;

        unique case (state_q)
            IDLE: begin
                if (bus.cfg_load) begin
                    key_d   = bus.cfg_key;
                    ctr_d   = bus.cfg_iv;
                    state_d = GEN;
                end
            end
            GEN: begin
                ks_d    = ks_next;
                state_d = WAIT_IN;
            end
            WAIT_IN: begin
                if (bus.in_valid) begin
                    odata_d  = bus.in_data ^ ks_q;
                    olast_d  = bus.in_last;
                    ovalid_d = 1'b1;
                    ctr_d    = (ctr_q & ~CtrMask) | ((ctr_q + aes_block_t'(1)) & CtrMask);
                    state_d  = WAIT_OUT;
                end
            end
            WAIT_OUT: begin
                if (bus.out_ready) begin
                    ovalid_d = 1'b0;
                    state_d  = olast_q ? IDLE : GEN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            key_q    <= '0;
            ctr_q    <= '0;
            ks_q     <= '0;
            odata_q  <= '0;
            olast_q  <= 1'b0;
            ovalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            ctr_q    <= ctr_d;
            ks_q     <= ks_d;
            odata_q  <= odata_d;
            olast_q  <= olast_d;
            ovalid_q <= ovalid_d;
        end
    end

    assign bus.in_ready  = (state_q == WAIT_IN);
    assign bus.out_valid = ovalid_q;
    assign bus.out_data  = odata_q;
    assign bus.out_last  = olast_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_aes_ctr_engine.sv
// Directed bench for aes_ctr_engine: SP800-38A CTR vectors, backpressure, counter wrap,
// round trip, ignored reconfiguration and mid-message reset.
module tb_aes_ctr_engine;

    localparam logic [127:0] Key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] Iv  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] C1  = 128'h874d6191b620e3261bef6864990db6ce;
    localparam logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] C2  = 128'h9806f66b7970fdff8617187bb9fffdff;
    localparam logic [127:0] IvW = 128'h0123456789abcdef00000001ffffffff;
    localparam logic [127:0] D1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] D2  = 128'hdeadbeef0badf00dcafebabe12345678;

    localparam logic [2047:0] SboxTab = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    aes_ctr_engine_if bus ();

    aes_ctr_engine #(.CTR_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] sb(input logic [7:0] b);
        logic [2047:0] tab;
        int            idx;
        tab = SboxTab;
        idx = int'(b);
        return tab[2047-8*idx -: 8];
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Reference AES-128: table S-box, full expanded key schedule, state as [row][col].
    function automatic logic [127:0] ref_aes(input logic [127:0] k, input logic [127:0] blk);
        logic [31:0]  w [44];
        logic [7:0]   s [4][4];
        logic [7:0]   n [4][4];
        logic [7:0]   rc;
        logic [31:0]  t;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[r][c] = blk[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) n[r][c] = sb(s[r][(c+r)%4]);
            for (int c = 0; c < 4; c++) begin
                if (rnd < 10) begin
                    s[0][c] = gm(n[0][c], 8'h02) ^ gm(n[1][c], 8'h03) ^ n[2][c] ^ n[3][c];
                    s[1][c] = n[0][c] ^ gm(n[1][c], 8'h02) ^ gm(n[2][c], 8'h03) ^ n[3][c];
                    s[2][c] = n[0][c] ^ n[1][c] ^ gm(n[2][c], 8'h02) ^ gm(n[3][c], 8'h03);
                    s[3][c] = gm(n[0][c], 8'h03) ^ n[1][c] ^ n[2][c] ^ gm(n[3][c], 8'h02);
                end else begin
                    for (int r = 0; r < 4; r++) s[r][c] = n[r][c];
                end
                for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ w[4*rnd+c][31-8*r -: 8];
            end
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) res[127-8*(4*c+r) -: 8] = s[r][c];
        return res;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [127:0] k, input logic [127:0] iv);
        bus.cfg_load = 1'b1;
        bus.cfg_key  = k;
        bus.cfg_iv   = iv;
        @(posedge clk);
        @(negedge clk);
        bus.cfg_load = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk(tag, 128'(bus.in_ready), 128'd1);
    endtask

    task automatic push(input logic [127:0] d, input logic last);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic pop();
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic block(input string tag, input logic [127:0] d, input logic last,
                         input logic [127:0] exp);
        wait_ready({tag, "_ready"});
        push(d, last);
        chk({tag, "_valid"}, 128'(bus.out_valid), 128'd1);
        chk({tag, "_data"}, bus.out_data, exp);
        chk({tag, "_last"}, 128'(bus.out_last), 128'(last));
        pop();
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.cfg_load  = 1'b0;
        bus.cfg_key   = '0;
        bus.cfg_iv    = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 128'(bus.busy), 128'd0);
        chk("rst_in_ready", 128'(bus.in_ready), 128'd0);
        chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("rst_out_data", bus.out_data, 128'd0);
        chk("rst_out_last", 128'(bus.out_last), 128'd0);
        rst_n = 1'b1;

        // cfg_load and in_valid together in IDLE: only the load acts.
        bus.in_valid = 1'b1;
        bus.in_data  = P1;
        bus.in_last  = 1'b0;
        chk("idle_in_ready", 128'(bus.in_ready), 128'd0);
        load(Key, Iv);
        chk("gen_busy", 128'(bus.busy), 128'd1);
        chk("gen_in_ready", 128'(bus.in_ready), 128'd0);
        chk("gen_out_valid", 128'(bus.out_valid), 128'd0);
        @(posedge clk);
        @(negedge clk);
        chk("wait_in_ready", 128'(bus.in_ready), 128'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("b1_valid", 128'(bus.out_valid), 128'd1);
        chk("b1_data", bus.out_data, C1);
        chk("b1_last", 128'(bus.out_last), 128'd0);

        // Backpressure on block 1.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_valid", 128'(bus.out_valid), 128'd1);
            chk("bp_data", bus.out_data, C1);
            chk("bp_in_ready", 128'(bus.in_ready), 128'd0);
        end
        pop();
        chk("b1_done_valid", 128'(bus.out_valid), 128'd0);
        chk("b1_done_busy", 128'(bus.busy), 128'd1);

        block("b2", P2, 1'b1, C2);
        chk("b2_done_busy", 128'(bus.busy), 128'd0);
        chk("b2_done_valid", 128'(bus.out_valid), 128'd0);

        // Round trip: decrypt block-1 ciphertext.
        load(Key, Iv);
        block("rt", C1, 1'b1, P1);
        chk("rt_done_busy", 128'(bus.busy), 128'd0);

        // cfg_load in WAIT_IN is ignored for both key and counter.
        load(Key, Iv);
        wait_ready("ign_ready");
        load(~Key, 128'd0);
        chk("ign_in_ready", 128'(bus.in_ready), 128'd1);
        block("ign_b1", P1, 1'b0, C1);
        block("ign_b2", P2, 1'b1, C2);

        // Low 32 counter bits wrap; the upper 96 bits stay put.
        load(Key, IvW);
        block("wrap_b1", D1, 1'b0, D1 ^ ref_aes(Key, IvW));
        block("wrap_b2", D2, 1'b1, D2 ^ ref_aes(Key, {IvW[127:32], 32'h0}));
        chk("wrap_done_busy", 128'(bus.busy), 128'd0);

        // Reset while holding a block in WAIT_OUT.
        load(Key, Iv);
        wait_ready("mrst_ready");
        push(P1, 1'b0);
        chk("mrst_pre_valid", 128'(bus.out_valid), 128'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mrst_valid", 128'(bus.out_valid), 128'd0);
        chk("mrst_busy", 128'(bus.busy), 128'd0);
        chk("mrst_in_ready", 128'(bus.in_ready), 128'd0);
        chk("mrst_data", bus.out_data, 128'd0);
        rst_n = 1'b1;
        load(Key, Iv);
        block("post_rst", P1, 1'b1, C1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_ctr_engine.md
Name: aes_ctr_engine

Overview:
Sequential AES-128 counter-mode front/back end wrapped around the combinational aes_core. It owns the key and counter registers that drive aes_core's key/block_in, and registers its block_out as keystream. It XORs the keystream with a handshaked 128-bit data stream to produce ciphertext or plaintext; the operation is symmetric. It sits between the bus-side data FIFO and the output buffer of the crypto datapath.

Parameters:
CTR_WIDTH, 32, number of low-order counter bits incremented per block (1..128); the upper 128-CTR_WIDTH bits are a fixed nonce.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
cfg_load  input  1  single-cycle pulse that latches cfg_key/cfg_iv and starts a message; honoured only in IDLE
cfg_key  input  128  AES-128 key
cfg_iv  input  128  initial counter block (nonce || counter)
in_valid  input  1  input data block valid
in_ready  output  1  engine accepts in_data this cycle
in_data  input  128  plaintext/ciphertext block
in_last  input  1  marks the final block of the message; sampled with in_data
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts out_data
out_data  output  128  in_data XOR keystream
out_last  output  1  copy of in_last for this block
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; key_q, ctr_q, ks_q, out_data, out_last = 0; in_ready=0, out_valid=0, busy=0. Reset dominates every other input, including mid-message; any partially processed block is discarded.
- The combinational aes_core is driven only from registers (key_q, ctr_q). Its output is captured only into ks_q, so the critical path is register -> aes_core -> register.
- IDLE: if cfg_load: key_q<=cfg_key, ctr_q<=cfg_iv, go to GEN.
- GEN (1 cycle): ks_q<=aes_core(key_q, ctr_q); go to WAIT_IN.
- WAIT_IN: in_ready=1. On in_valid: out_data<=in_data^ks_q, out_last<=in_last, out_valid<=1, ctr_q<=increment(ctr_q); go to WAIT_OUT.
- WAIT_OUT: out_valid=1; out_data and out_last are held stable until out_ready. On out_ready: out_valid<=0, then go to IDLE if out_last=1, else to GEN.
- Latency: from accepting a block in WAIT_IN, out_valid rises on the next edge. Steady-state throughput is one block per 3 cycles when out_ready is tied high.
- Counter increment: ctr_q[CTR_WIDTH-1:0] <= ctr_q[CTR_WIDTH-1:0]+1, modulo 2^CTR_WIDTH (wraps silently). ctr_q[127:CTR_WIDTH] is never modified.
- cfg_load outside IDLE is ignored; key and counter are unchanged.
- in_ready is 0 in every state except WAIT_IN. in_valid is not sampled elsewhere, and data there is neither consumed nor dropped.
- in_valid and cfg_load in IDLE in the same cycle: only cfg_load acts; the data waits for WAIT_IN.
- A new message requires a fresh cfg_load. The key is never reused implicitly across messages.
- Byte order matches aes_core: bit 127 is the first byte of the block.

Decomposition:
- Package aes_pkg: localparam AES_BLK_W=128, AES_KEY_W=128; typedef logic [127:0] aes_block_t; enum state_t {IDLE, GEN, WAIT_IN, WAIT_OUT}.
- One sub-module: the existing aes_core, instantiated once. Counter increment and XOR stay inline.

Test Plan:
- SP800-38A F.5.1, block 1: cfg_key=2b7e151628aed2a6abf7158809cf4f3c, cfg_iv=f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, in_data=6bc1bee22e409f96e93d7e117393172a -> out_data=874d6191b620e3261bef6864990db6ce.
- Block 2 of the same message: in_data=ae2d8a571e03ac9c9eb76fac45af8e51 with in_last=1 -> out_data=9806f66b7970fdff8617187bb9fffdff, out_last=1; busy=0 after out_ready.
- Backpressure: hold out_ready=0 for 10 cycles -> out_valid stays 1, out_data stable, in_ready=0 throughout; the block completes when out_ready=1.
- Counter wrap (CTR_WIDTH=32): cfg_iv=...00000001_ffffffff, send two blocks -> the second keystream uses ctr ...00000001_00000000 (low 32 bits wrap, upper 96 bits unchanged); check against a model.
- Round trip: feed the block-1 ciphertext back with the same cfg_key/cfg_iv -> out_data=6bc1bee22e409f96e93d7e117393172a.
- Reset and ignored config: assert rst_n=0 in WAIT_OUT -> next cycle out_valid=0, busy=0, state IDLE. Separately, cfg_load with a different key in WAIT_IN -> ignored, and the block-1 vector still matches.
